branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the 5-stage pipeline core. Branches and jumps in the current core resolve in ID and always cost a flush; this block lets IF speculate.
- **IF side:** the fetch PC is looked up combinationally to produce a predicted next PC.
- **ID side:** branch resolution is written back into the table on the clock edge, and the block flags mispredictions and supplies the corrective PC.
- **Statistics:** resolved-branch and mispredict counters are exposed for the display path.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- ENTRIES, 16, number of BTB entries; power of two, minimum 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width; minimum 1.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lookup_pc  in  ADDR_W  current fetch PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_target  out  ADDR_W  stored target when pred_hit, else 0.
- update_valid  in  1  a control-transfer instruction resolves this cycle.
- update_pc  in  ADDR_W  PC of the resolving instruction.
- update_taken  in  1  actual outcome.
- update_target  in  ADDR_W  actual target; used only when taken.
- update_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- update_pred_target  in  ADDR_W  predicted target carried down the pipe.
- flush_table  in  1  synchronous invalidate of all entries.
- mispredict  out  1  combinational misprediction flag.
- redirect_pc  out  ADDR_W  correct next PC.
- branch_cnt  out  STAT_W  number of resolved updates.
- mispredict_cnt  out  STAT_W  number of mispredictions.

## Operation
Address fields:
- index = pc[IDX_W+1:2].
- tag = pc[ADDR_W-1:IDX_W+2].
- pc[1:0] is ignored.

Entry contents: valid, tag, target[ADDR_W], ctr[CTR_W].

Lookup (combinational):
- pred_hit = valid[idx] and tag match.
- pred_taken = pred_hit and ctr[CTR_W-1].
- pred_target = pred_hit ? target : 0.

mispredict = update_valid and (update_taken != update_pred_taken, or (update_taken and update_pred_target != update_target)).

redirect_pc = update_taken ? update_target : update_pc + 4, computed modulo 2^ADDR_W.

Table update, on the clock edge when update_valid = 1:
- **Tag hit:**
  - If taken: ctr = min(ctr+1, 2^CTR_W−1) and target = update_target.
  - If not taken: ctr = max(ctr−1, 0); target is unchanged.
- **Miss and taken:** allocate (overwrite) the entry with valid = 1, tag, target = update_target, ctr = 2^(CTR_W−1) (weakly taken).
- **Miss and not taken:** no table change.

Statistics, on the clock edge when update_valid = 1:
- branch_cnt increments.
- mispredict_cnt increments if mispredict = 1.
- Both saturate at all-ones; no wrap.

flush_table:
- Clears all valid bits at the next edge.
- It wins over a simultaneous table update: no allocation and no counter change in the table.
- Statistics still count the update that cycle.

Lookup and update hitting the same index in the same cycle: the lookup returns pre-edge contents. There is no bypass.

## Timing
Reset (asynchronous):
- All valid bits = 0; ctr and target contents are don't-care.
- branch_cnt = 0, mispredict_cnt = 0.
- As a result pred_hit = 0, pred_taken = 0, pred_target = 0.
- mispredict and redirect_pc are combinational from the inputs and remain defined during reset.

Latency:
- Lookup is 0 cycles (same cycle as lookup_pc).
- An update is visible to lookup from the cycle after the edge.
- Statistics are visible the cycle after the edge.

Reset asserted mid-operation discards any pending update at that edge.

No handshake: update_valid is a single-cycle strobe, and consecutive-cycle updates are all applied.

## Test plan
1. **Reset, then allocate a taken branch.**
   - Stimulus: assert reset, then lookup_pc = 0x00400010.
   - Required: pred_hit = 0, both stat counters = 0.
   - Stimulus: update_valid with pc 0x00400010, taken, target 0x00400040, pred_taken = 0.
   - Required: mispredict = 1, redirect_pc = 0x00400040, mispredict_cnt = 1 next cycle.
   - Required next cycle: lookup of 0x00400010 gives pred_hit = 1, pred_taken = 1 (ctr = 2), pred_target = 0x00400040.
2. **Counter saturation.**
   - Stimulus: five consecutive not-taken updates on the entry from scenario 1 (ctr 2 → 1 → 0 → 0 …).
   - Required: pred_taken = 0 after the first update; ctr stays at 0 (observable because two taken updates are then needed to restore pred_taken = 1).
   - Required: redirect_pc = 0x00400014 on each not-taken update.
3. **Aliasing.**
   - Stimulus: taken update at 0x00400050 (same index as 0x00400010, different tag).
   - Required: lookup of 0x00400010 misses; lookup of 0x00400050 hits.
   - Stimulus: not-taken update on a missing PC.
   - Required: no allocation.
4. **Target change.**
   - Stimulus: update on a hitting entry with taken, pred_target 0x00400040, actual target 0x00400080.
   - Required: mispredict = 1; the new target is stored.
5. **flush_table with a simultaneous taken update.**
   - Required next cycle: all lookups miss; branch_cnt has incremented.
6. **Statistics saturation.**
   - Stimulus: STAT_W = 4, 20 mispredicted updates.
   - Required: branch_cnt = mispredict_cnt = 15.
   - Stimulus: reset asserted mid-stream.
   - Required: both counters = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// IF looks up combinationally; ID resolutions train the table and statistics on the clock edge.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_pred_taken,
    input  logic [ADDR_W-1:0] update_pred_target,
    input  logic              flush_table,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        return (&c) ? c : c + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];
    logic [STAT_W-1:0]  r_branch_cnt;
    logic [STAT_W-1:0]  r_mispredict_cnt;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic               w_alloc;
    logic               w_mispredict;
    logic               w_unused_pc_lsbs;

    // Byte offset within the word never selects an entry.
    assign w_unused_pc_lsbs = &lookup_pc[1:0];

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign w_up_idx = update_pc[IDX_W+1:2];
    assign w_up_tag = update_pc[ADDR_W-1:IDX_W+2];

    assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign pred_target = pred_hit ? r_target[w_lk_idx] : '0;

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_alloc  = update_valid && !flush_table && !w_up_hit && update_taken;

    // Target compare matters only when the branch was actually taken.
    assign w_mispredict = update_valid &&
                          ((update_taken != update_pred_taken) ||
                           (update_taken && (update_pred_target != update_target)));
    assign mispredict   = w_mispredict;
    assign redirect_pc  = update_taken ? update_target : update_pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (flush_table) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Entry payload carries no reset; an invalid entry's contents are never observed.
    always_ff @(posedge clk) begin
        if (update_valid && !flush_table) begin
            if (w_up_hit) begin
                if (update_taken) begin
                    r_ctr[w_up_idx]    <= ctr_inc(r_ctr[w_up_idx]);
                    r_target[w_up_idx] <= update_target;
                end else begin
                    r_ctr[w_up_idx]    <= ctr_dec(r_ctr[w_up_idx]);
                end
            end else if (update_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= update_target;
                r_ctr[w_up_idx]    <= CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (update_valid) begin
            r_branch_cnt <= stat_inc(r_branch_cnt);
            if (w_mispredict) begin
                r_mispredict_cnt <= stat_inc(r_mispredict_cnt);
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: default instance plus a STAT_W=4 instance for counter saturation.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] update_pred_target;
    logic        flush_table;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, branch_cnt, mispredict_cnt;

    logic        s_pred_hit, s_pred_taken, s_mispredict;
    logic [31:0] s_pred_target, s_redirect_pc;
    logic [3:0]  s_branch_cnt, s_mispredict_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor u_dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target), .flush_table(flush_table),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_predictor #(.STAT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target), .flush_table(flush_table),
        .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
        .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        update_valid       = 1'b1;
        update_pc          = pc;
        update_taken       = tk;
        update_target      = tgt;
        update_pred_taken  = ptk;
        update_pred_target = ptgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        flush_table  = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        lookup_pc = pc;
        #1;
        chk({tag, "_hit"}, 64'(pred_hit), 64'(hit));
        chk({tag, "_taken"}, 64'(pred_taken), 64'(tk));
        chk({tag, "_target"}, 64'(pred_target), 64'(tgt));
    endtask

    initial begin
        reset = 1'b1; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; update_pred_taken = 1'b0;
        update_pred_target = '0; flush_table = 1'b0;

        // Reset state, and combinational outputs stay defined during reset
        #12;
        look("rst", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        chk("rst_bcnt", 64'(branch_cnt), 64'd0);
        chk("rst_mcnt", 64'(mispredict_cnt), 64'd0);
        update_pc = 32'h0000_0100;
        #1;
        chk("rst_redirect", 64'(redirect_pc), 64'h104);
        chk("rst_mispredict", 64'(mispredict), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1: allocate a taken branch
        upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        chk("s1_mispredict", 64'(mispredict), 64'd1);
        chk("s1_redirect", 64'(redirect_pc), 64'h0040_0040);
        chk("s1_no_bypass", 64'(pred_hit), 64'd0);
        tick();
        chk("s1_mcnt", 64'(mispredict_cnt), 64'd1);
        chk("s1_bcnt", 64'(branch_cnt), 64'd1);
        look("s1", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);

        // Scenario 2: counter saturates at 0
        for (int i = 0; i < 5; i++) begin
            upd(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("s2_redirect", 64'(redirect_pc), 64'h0040_0014);
            chk("s2_no_misp", 64'(mispredict), 64'd0);
            tick();
            if (i == 0) look("s2_first", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040);
        end
        upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0040);
        tick();
        look("s2_one_taken", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040);
        upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0040);
        tick();
        look("s2_two_taken", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
        chk("s2_bcnt", 64'(branch_cnt), 64'd8);
        chk("s2_mcnt", 64'(mispredict_cnt), 64'd3);

        // Scenario 3: aliasing and no allocation on not-taken miss
        upd(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        tick();
        look("s3_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        look("s3_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0100);
        upd(32'h0040_0090, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        look("s3_nt_miss", 32'h0040_0090, 1'b0, 1'b0, 32'h0);
        look("s3_kept", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0100);
        chk("s3_bcnt", 64'(branch_cnt), 64'd10);
        chk("s3_mcnt", 64'(mispredict_cnt), 64'd4);

        // Scenario 4: target change and target-only misprediction rules
        upd(32'h0040_0050, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040);
        chk("s4_misp", 64'(mispredict), 64'd1);
        chk("s4_redirect", 64'(redirect_pc), 64'h0040_0080);
        tick();
        look("s4_newtgt", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0080);
        upd(32'h0040_0050, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080);
        chk("s4_correct", 64'(mispredict), 64'd0);
        tick();
        upd(32'h0040_0050, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
        chk("s4_nt_tgt_ignored", 64'(mispredict), 64'd0);
        chk("s4_nt_redirect", 64'(redirect_pc), 64'h0040_0054);
        tick();
        look("s4_after_nt", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0080);
        chk("s4_bcnt", 64'(branch_cnt), 64'd13);
        chk("s4_mcnt", 64'(mispredict_cnt), 64'd5);
        update_pc = 32'hFFFF_FFFC; update_taken = 1'b0;
        #1;
        chk("redirect_wrap", 64'(redirect_pc), 64'h0);

        // Scenario 5: flush wins over a simultaneous taken update
        flush_table = 1'b1;
        upd(32'h0040_0020, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
        tick();
        look("s5_a", 32'h0040_0050, 1'b0, 1'b0, 32'h0);
        look("s5_b", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
        look("s5_c", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        chk("s5_bcnt", 64'(branch_cnt), 64'd14);
        chk("s5_mcnt", 64'(mispredict_cnt), 64'd5);

        // Scenario 6: statistics saturation and asynchronous mid-stream reset
        reset = 1'b1;
        #1;
        chk("s6_rst_bcnt", 64'(branch_cnt), 64'd0);
        chk("s6_rst_s_bcnt", 64'(s_branch_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
            tick();
        end
        chk("s6_sat_bcnt", 64'(s_branch_cnt), 64'd15);
        chk("s6_sat_mcnt", 64'(s_mispredict_cnt), 64'd15);
        chk("s6_wide_bcnt", 64'(branch_cnt), 64'd20);
        chk("s6_wide_mcnt", 64'(mispredict_cnt), 64'd20);
        upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        chk("s6_async_bcnt", 64'(branch_cnt), 64'd0);
        chk("s6_async_mcnt", 64'(mispredict_cnt), 64'd0);
        chk("s6_async_s_bcnt", 64'(s_branch_cnt), 64'd0);
        chk("s6_async_s_mcnt", 64'(s_mispredict_cnt), 64'd0);
        tick();
        chk("s6_discard_bcnt", 64'(branch_cnt), 64'd0);
        look("s6_discard", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
